// File: rtl/adain_pass_seq_if.sv
// rtl/adain_pass_seq_if.sv - command, feature-buffer and AdaIN datapath signal bundle
interface adain_pass_seq_if #(
    parameter int WIDTH_IN = 48,
    parameter int N_MAX    = 256
);
    localparam int NW = $clog2(N_MAX + 1);
    localparam int AW = $clog2(N_MAX * N_MAX);

    logic                cmd_valid;
    logic                cmd_ready;
    logic [NW-1:0]       cmd_n;
    logic [WIDTH_IN-1:0] cmd_ys;
    logic [WIDTH_IN-1:0] cmd_yb;
    logic                abort;

    logic                rd_en;
    logic [AW-1:0]       rd_addr;
    logic [WIDTH_IN-1:0] rd_data;

    logic [1:0]          ad_start;
    logic [NW-1:0]       ad_n;
    logic [WIDTH_IN-1:0] ad_in;
    logic [WIDTH_IN-1:0] ad_ys;
    logic [WIDTH_IN-1:0] ad_yb;
    logic [1:0]          ad_done;

    logic                busy;
    logic                frame_done;
    logic                err;
    logic [1:0]          phase;

    modport slave (
        input  cmd_valid, cmd_n, cmd_ys, cmd_yb, abort, rd_data, ad_done,
        output cmd_ready, rd_en, rd_addr, ad_start, ad_n, ad_in, ad_ys, ad_yb,
               busy, frame_done, err, phase
    );

    modport master (
        output cmd_valid, cmd_n, cmd_ys, cmd_yb, abort, rd_data, ad_done,
        input  cmd_ready, rd_en, rd_addr, ad_start, ad_n, ad_in, ad_ys, ad_yb,
               busy, frame_done, err, phase
    );
endinterface

// File: rtl/adain_pass_seq.sv
// rtl/adain_pass_seq.sv - three-pass AdaIN frame sequencer (MEAN, VAR, NORM)
module adain_pass_seq #(
    parameter int WIDTH_IN = 48,
    parameter int N_MAX    = 256,
    parameter int GAP_CYC  = 5,
    parameter int TIMEOUT  = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    adain_pass_seq_if.slave bus
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int NW = $clog2(N_MAX + 1);
    localparam int AW = $clog2(N_MAX * N_MAX);
    // One counter serves pixels, WAIT timeout and GAP; 17 bits minimum keeps P=65536 from wrapping.
    localparam int CW = max2(max2(17, 2 * NW), max2($clog2(TIMEOUT + 1), $clog2(GAP_CYC + 1)));
    localparam logic [1:0] PH_MEAN = 2'b01;
    localparam logic [1:0] PH_NORM = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFETCH,
        S_STREAM,
        S_WAIT,
        S_GAP,
        S_FINISH,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NW-1:0]       n_q, n_d;
    logic [WIDTH_IN-1:0] ys_q, ys_d;
    logic [WIDTH_IN-1:0] yb_q, yb_d;
    logic                err_q, err_d;

    logic                rd_en_c;
    logic [AW-1:0]       rd_addr_c;
    logic [1:0]          ad_start_c;
    logic [WIDTH_IN-1:0] ad_in_c;
    logic                frame_done_c;

    logic [CW-1:0]       p_total;
    logic [CW-1:0]       cnt_inc;
    logic                last_pix;
    logic                next_exists;
    logic                cmd_bad;

    assign p_total     = CW'(n_q) * CW'(n_q);
    assign cnt_inc     = cnt_q + CW'(1);
    assign last_pix    = (cnt_q == p_total - CW'(1));
    assign next_exists = (cnt_inc < p_total);
    assign cmd_bad     = (bus.cmd_n == '0) || (bus.cmd_n > NW'(N_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= 2'b00;
            cnt_q   <= '0;
            n_q     <= '0;
            ys_q    <= '0;
            yb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            ys_q    <= ys_d;
            yb_q    <= yb_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        n_d          = n_q;
        ys_d         = ys_q;
        yb_d         = yb_q;
        err_d        = err_q;
        rd_en_c      = 1'b0;
        rd_addr_c    = '0;
        ad_start_c   = 2'b00;
        ad_in_c      = '0;
        frame_done_c = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.cmd_valid) begin
                    n_d   = bus.cmd_n;
                    ys_d  = bus.cmd_ys;
                    yb_d  = bus.cmd_yb;
                    err_d = cmd_bad;
                    if (cmd_bad) begin
                        state_d = S_ERR;
                        phase_d = 2'b00;
                    end else begin
                        state_d = S_PREFETCH;
                        phase_d = PH_MEAN;
                    end
                end
            end
            S_PREFETCH: begin
                rd_en_c = 1'b1;
                cnt_d   = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                // Buffer read latency is one cycle, so the address runs one pixel ahead of ad_in.
                ad_in_c = bus.rd_data;
                if (cnt_q == '0) begin
                    ad_start_c = phase_q;
                end
                if (next_exists) begin
                    rd_en_c   = 1'b1;
                    rd_addr_c = AW'(cnt_inc);
                end
                if (last_pix) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT: begin
                if (bus.ad_done == phase_q) begin
                    cnt_d = '0;
                    if (phase_q == PH_NORM) begin
                        state_d = S_FINISH;
                    end else if (GAP_CYC == 0) begin
                        state_d = S_PREFETCH;
                        phase_d = phase_q + 2'd1;
                    end else begin
                        state_d = S_GAP;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    state_d = S_PREFETCH;
                    phase_d = phase_q + 2'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_FINISH: begin
                frame_done_c = 1'b1;
                state_d      = S_IDLE;
            end
            S_ERR: begin
                frame_done_c = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any transition, including a timeout or a matching done this cycle.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            err_d   = err_q;
        end
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.phase      = (state_q == S_IDLE) ? 2'b00 : phase_q;
    assign bus.rd_en      = rd_en_c;
    assign bus.rd_addr    = rd_addr_c;
    assign bus.ad_start   = ad_start_c;
    assign bus.ad_in      = ad_in_c;
    assign bus.ad_n       = n_q;
    assign bus.ad_ys      = ys_q;
    assign bus.ad_yb      = yb_q;
    assign bus.frame_done = frame_done_c;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_adain_pass_seq.sv
// tb/tb_adain_pass_seq.sv - self-checking bench for adain_pass_seq
module tb_adain_pass_seq;
    localparam int WIDTH_IN = 48;
    localparam int N_MAX    = 256;
    localparam int GAP_CYC  = 5;
    localparam int TIMEOUT  = 1024;
    localparam int NW       = $clog2(N_MAX + 1);
    localparam int AW       = $clog2(N_MAX * N_MAX);
    localparam int NEVER    = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adain_pass_seq_if #(.WIDTH_IN(WIDTH_IN), .N_MAX(N_MAX)) bus ();

    adain_pass_seq #(
        .WIDTH_IN(WIDTH_IN),
        .N_MAX   (N_MAX),
        .GAP_CYC (GAP_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic                ready;
        logic                busy;
        logic [1:0]          phase;
        logic                rd_en;
        logic [AW-1:0]       rd_addr;
        logic [1:0]          ad_start;
        logic [WIDTH_IN-1:0] ad_in;
        logic                frame_done;
        logic                err;
        logic [NW-1:0]       ad_n;
        logic [WIDTH_IN-1:0] ad_ys;
        logic [WIDTH_IN-1:0] ad_yb;
    } obs_t;

    typedef struct {
        string name;
        int    n;
        int    lat0, lat1, lat2;
        bit    wrong;
        int    ab;
        int    junk;
        int    rst;
        bit    ramp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH_IN-1:0] mem [32];
    int  m_n, m_p, m_nstart, m_fd, m_last_busy, m_err_from, m_ab, m_junk, m_rst, m_rst_req;
    int  m_s [3];
    int  m_d [3];
    int  m_lat [3];
    bit  m_bad, m_wrong;
    logic [WIDTH_IN-1:0] m_ys, m_yb;

    task automatic check(input string name, input longint got, input longint want, input string info);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d %s", name, got, want, info);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.ready      = bus.cmd_ready;
        o.busy       = bus.busy;
        o.phase      = bus.phase;
        o.rd_en      = bus.rd_en;
        o.rd_addr    = bus.rd_addr;
        o.ad_start   = bus.ad_start;
        o.ad_in      = bus.ad_in;
        o.frame_done = bus.frame_done;
        o.err        = bus.err;
        o.ad_n       = bus.ad_n;
        o.ad_ys      = bus.ad_ys;
        o.ad_yb      = bus.ad_yb;
        return o;
    endfunction

    // Event timeline of one frame, counted in cycles from the accept cycle (cycle 0).
    task automatic plan();
        m_bad = (m_n == 0) || (m_n > N_MAX);
        m_p = m_n * m_n;
        m_nstart = 0;
        m_fd = -1;
        m_err_from = NEVER;
        m_last_busy = 0;
        for (int ph = 0; ph < 3; ph++) begin
            m_s[ph] = -100;
            m_d[ph] = -100;
        end
        if (m_bad) begin
            m_fd = 1;
            m_last_busy = 1;
            m_err_from = 1;
        end else begin
            m_s[0] = 2;
            for (int ph = 0; ph < 3; ph++) begin
                m_nstart = ph + 1;
                if (m_lat[ph] < 0) begin
                    m_fd = m_s[ph] + m_p + TIMEOUT;
                    m_err_from = m_fd;
                    m_last_busy = m_fd;
                    break;
                end
                m_d[ph] = m_s[ph] + m_p - 1 + m_lat[ph];
                if (ph < 2) begin
                    m_s[ph+1] = m_d[ph] + GAP_CYC + 2;
                end else begin
                    m_fd = m_d[ph] + 1;
                    m_last_busy = m_fd;
                end
            end
        end
        if (m_ab >= 1 && m_ab <= m_last_busy) begin
            m_last_busy = m_ab;
            if (m_fd > m_ab) m_fd = -1;
            if (m_err_from > m_ab) m_err_from = NEVER;
        end
        m_rst = (m_rst_req == -2) ? m_s[2] + 1 : m_rst_req;
    endtask

    task automatic expect_at(input int c, output obs_t e, output obs_t m);
        bit busy;
        int k;
        e = '0;
        m = '1;
        if (m_rst >= 0 && c > m_rst) begin
            e.ready = 1'b1;
            return;
        end
        busy = (c >= 1) && (c <= m_last_busy);
        e.busy = busy;
        e.ready = !busy;
        for (int ph = 0; ph < m_nstart; ph++) begin
            if (!busy) continue;
            if (c >= m_s[ph] - 1) e.phase = 2'(ph + 1);
            if (c == m_s[ph] - 1) begin
                e.rd_en = 1'b1;
                e.rd_addr = '0;
            end
            k = c - m_s[ph];
            if (k >= 0 && k < m_p) begin
                e.ad_in = mem[k];
                if (k == 0) e.ad_start = 2'(ph + 1);
                if (k + 1 < m_p) begin
                    e.rd_en = 1'b1;
                    e.rd_addr = AW'(k + 1);
                end
            end
        end
        e.frame_done = (c == m_fd);
        e.err = (c >= m_err_from);
        e.ad_n = NW'(m_n);
        e.ad_ys = m_ys;
        e.ad_yb = m_yb;
        if (c == 0) begin
            m.err = 1'b0;
            m.ad_n = '0;
            m.ad_ys = '0;
            m.ad_yb = '0;
        end
        if (!e.rd_en) m.rd_addr = '0;
    endtask

    task automatic run_frame(input string name);
        obs_t got, e, m;
        int bad_cnt, last;
        string first;
        bad_cnt = 0;
        first = "";
        last = (m_rst >= 0) ? m_rst + 6 : m_last_busy + 4;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            got = sample();
            expect_at(c, e, m);
            if (((got ^ e) & m) != '0) begin
                bad_cnt++;
                if (first == "") first = $sformatf("first at cycle %0d: dut %h model %h", c, got, e);
            end
            bus.cmd_valid = (c == 0) || (c == m_junk);
            bus.cmd_n     = (c == 0) ? NW'(m_n) : NW'(3);
            bus.cmd_ys    = (c == 0) ? m_ys : ~m_ys;
            bus.cmd_yb    = (c == 0) ? m_yb : ~m_yb;
            bus.abort     = (c == m_ab);
            bus.ad_done   = 2'b00;
            for (int ph = 0; ph < m_nstart; ph++) begin
                if (m_lat[ph] < 0) continue;
                if (c == m_d[ph]) bus.ad_done = 2'(ph + 1);
                else if (m_wrong && m_lat[ph] >= 2 && c == m_d[ph] - 1)
                    bus.ad_done = (ph == 2) ? 2'b01 : 2'(ph + 2);
            end
            bus.rd_data = (got.rd_en && got.rd_addr < 32) ? mem[got.rd_addr[4:0]] : '0;
            if (c == m_rst) begin
                rst_n = 1'b0;
                #1;
                got = sample();
                e = '0;
                e.ready = 1'b1;
                check({name, "_async_reset"}, (got !== e) ? 1 : 0, 0,
                      $sformatf("dut %h model %h", got, e));
            end
            if (m_rst >= 0 && c == m_rst + 2) rst_n = 1'b1;
        end
        check(name, bad_cnt, 0, first);
        bus.cmd_valid = 1'b0;
        bus.abort = 1'b0;
        bus.ad_done = 2'b00;
    endtask

    task automatic apply(input vec_t v);
        m_n = v.n;
        m_lat[0] = v.lat0;
        m_lat[1] = v.lat1;
        m_lat[2] = v.lat2;
        m_wrong = v.wrong;
        m_ab = v.ab;
        m_junk = v.junk;
        m_rst_req = v.rst;
        for (int k = 0; k < 32; k++)
            mem[k] = v.ramp ? (WIDTH_IN'(k + 1) << 16) : WIDTH_IN'({$urandom(), $urandom()});
        m_ys = v.ramp ? 48'h1_8000 : WIDTH_IN'({$urandom(), $urandom()});
        m_yb = v.ramp ? 48'h0_8000 : WIDTH_IN'({$urandom(), $urandom()});
        plan();
        run_frame(v.name);
    endtask

    vec_t tbl [11];
    obs_t rst_exp, rst_got;

    initial begin
        tbl[0]  = '{"basic_n2",         2,   3,  3, 3, 1'b0, -1, -1, -1, 1'b1};
        tbl[1]  = '{"reject_n0",        0,   3,  3, 3, 1'b0, -1, -1, -1, 1'b0};
        tbl[2]  = '{"reject_n257",      257, 3,  3, 3, 1'b0, -1, -1, -1, 1'b0};
        tbl[3]  = '{"n1_clears_err",    1,   2,  4, 1, 1'b0, -1, -1, -1, 1'b0};
        tbl[4]  = '{"wrong_done_code",  2,   4,  2, 3, 1'b1, -1, -1, -1, 1'b0};
        tbl[5]  = '{"abort_idle_busy_cmd", 3, 1, 5, 2, 1'b0,  0,  5, -1, 1'b0};
        tbl[6]  = '{"timeout_var",      2,   3, -1, 3, 1'b0, -1, -1, -1, 1'b0};
        tbl[7]  = '{"abort_mean_s2",    2,   3,  3, 3, 1'b0,  4, -1, -1, 1'b1};
        tbl[8]  = '{"after_abort",      2,   2,  2, 2, 1'b0, -1, -1, -1, 1'b1};
        tbl[9]  = '{"reset_norm",       2,   3,  3, 3, 1'b0, -1, -1, -2, 1'b0};
        tbl[10] = '{"after_reset",      1,   1,  1, 1, 1'b1, -1, -1, -1, 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_n     = '0;
        bus.cmd_ys    = '0;
        bus.cmd_yb    = '0;
        bus.abort     = 1'b0;
        bus.rd_data   = '0;
        bus.ad_done   = 2'b00;

        rst_exp = '0;
        rst_exp.ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_got = sample();
        check("reset_held", (rst_got !== rst_exp) ? 1 : 0, 0, $sformatf("dut %h", rst_got));
        rst_n = 1'b1;
        @(negedge clk);
        rst_got = sample();
        check("reset_released", (rst_got !== rst_exp) ? 1 : 0, 0, $sformatf("dut %h", rst_got));

        for (int i = 0; i < 11; i++) apply(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v.name  = $sformatf("random_%0d", i);
            v.n     = int'($urandom_range(5, 1));
            v.lat0  = int'($urandom_range(6, 1));
            v.lat1  = int'($urandom_range(6, 1));
            v.lat2  = int'($urandom_range(6, 1));
            v.wrong = 1'($urandom_range(1, 0));
            v.ab    = -1;
            v.junk  = int'($urandom_range(v.n * v.n + 1, 1));
            v.rst   = -1;
            v.ramp  = 1'b0;
            apply(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/adain_pass_seq.md
ADAIN_PASS_SEQ -- requirements
Module: adain_pass_seq

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 48, pixel/ys/yb width (Q16.16 sign-extended).
REQ-002 SHALL have parameter N_MAX, default 256, maximum feature-map side length.
REQ-003 SHALL have parameter GAP_CYC, default 5, idle cycles between passes.
REQ-004 SHALL have parameter TIMEOUT, default 1024, max cycles waiting for done per pass.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port cmd_valid  input  1  frame command request.
REQ-008 SHALL have port cmd_ready  output  1  high only in IDLE.
REQ-009 SHALL have port cmd_n  input  $clog2(N_MAX+1)  side length N; pixel count P = N*N.
REQ-010 SHALL have ports cmd_ys and cmd_yb  input  WIDTH_IN  style scale and bias.
REQ-011 SHALL have port abort  input  1  synchronous frame abort.
REQ-012 SHALL have ports rd_en  output  1 and rd_addr  output  $clog2(N_MAX*N_MAX)  feature-buffer read; rd_data valid exactly 1 cycle after rd_en.
REQ-013 SHALL have port rd_data  input  WIDTH_IN  feature-buffer read data.
REQ-014 SHALL have ports ad_start  output  2, ad_n  output  $clog2(N_MAX+1), ad_in, ad_ys, ad_yb  output  WIDTH_IN  AdaIN datapath drive.
REQ-015 SHALL have port ad_done  input  2  AdaIN pass-complete code.
REQ-016 SHALL have ports busy, frame_done, err  output  1 each, and phase  output  2  current pass code.

Function
REQ-017 SHALL latch cmd_n, cmd_ys, cmd_yb on cmd_valid&&cmd_ready; ad_n/ad_ys/ad_yb SHALL hold latched values until next accept.
REQ-018 SHALL reject accepted commands with N=0 or N>N_MAX: err=1, one-cycle frame_done, no rd_en/ad_start, return to IDLE next cycle.
REQ-019 SHALL run three passes in fixed order, phase codes 2'b01 MEAN, 2'b10 VAR, 2'b11 NORM; phase=0 in IDLE.
REQ-020 Per-pass states SHALL be PREFETCH -> STREAM -> WAIT -> GAP; after NORM's WAIT, go to FINISH then IDLE.
REQ-021 PREFETCH SHALL last 1 cycle: rd_en=1, rd_addr=0.
REQ-022 STREAM SHALL last P cycles; in STREAM cycle k (k=0..P-1) ad_in = rd_data (pixel k), and rd_en=1 with rd_addr=k+1 while k+1<P.
REQ-023 ad_start SHALL equal the phase code only in STREAM cycle 0, else 2'b00.
REQ-024 ad_in SHALL be 0 whenever not in STREAM.
REQ-025 WAIT SHALL exit when ad_done == phase code; other nonzero ad_done values SHALL be ignored.
REQ-026 WAIT SHALL count cycles; reaching TIMEOUT without matching done sets err=1, pulses frame_done, returns to IDLE.
REQ-027 GAP SHALL last exactly GAP_CYC cycles with rd_en=0, ad_start=0, then PREFETCH of the next phase.
REQ-028 FINISH SHALL pulse frame_done for exactly 1 cycle with err=0.
REQ-029 err SHALL be sticky until next accepted command, then cleared in the accept cycle.
REQ-030 abort in any non-IDLE state SHALL force IDLE next cycle: rd_en=0, ad_start=0, no frame_done, err unchanged; abort in IDLE ignored.
REQ-031 abort and a matching ad_done in the same cycle: abort wins.
REQ-032 busy SHALL be 1 in every non-IDLE state; cmd_valid while busy SHALL be ignored (not queued).
REQ-033 Pixel counter SHALL be at least 17 bits wide so P=65536 does not wrap; rd_addr SHALL never exceed P-1.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE and counters to 0.
REQ-035 During and after reset: cmd_ready=1 (after release), busy=0, phase=0, rd_en=0, rd_addr=0, ad_start=0, ad_in=0, ad_n=0, ad_ys=0, ad_yb=0, frame_done=0, err=0.
REQ-036 Reset asserted mid-frame SHALL abandon the frame with no frame_done pulse.

Verification
REQ-037 N=2, buffer {0x10000,0x20000,0x30000,0x40000}, ad_done model echoes phase 3 cycles after stream end -> ad_start 01/10/11 once each, ad_in sequence 1,2,3,4 (Q16.16) from start cycle each pass, 5 idle cycles between passes, one frame_done, err=0.
REQ-038 cmd_n=0, then cmd_n=257 -> err=1, frame_done pulse, no rd_en or ad_start toggles; next valid command clears err.
REQ-039 N=2, ad_done never returns during VAR -> err=1 exactly TIMEOUT cycles into WAIT, frame_done pulse, NORM never started.
REQ-040 abort in MEAN STREAM cycle 2 -> IDLE next cycle, ad_in=0, no frame_done; new command then completes normally.
REQ-041 ad_done=2'b10 injected during MEAN WAIT -> ignored; only 2'b01 advances to GAP.
REQ-042 rst_n low during NORM STREAM -> all outputs at reset values immediately (async), no frame_done after release.
